// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute-stage request/response handshake plus the combined_memory port.
interface load_store_unit_if #(
    parameter int WORD_SIZE = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 resp_valid;
    logic [WORD_SIZE-1:0] resp_rdata;
    logic                 resp_fault;
    logic                 mem_write_en;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_write_data;
    logic [1:0]           mem_ctrl;
    logic [WORD_SIZE-1:0] mem_data;
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_write_en, mem_addr, mem_write_data, mem_ctrl
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_write_en, mem_addr, mem_write_data, mem_ctrl
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one load/store per transaction into combined_memory, with funct3 decode,
// load extension and fault reporting for illegal or misaligned requests.
module load_store_unit #(
    parameter int WORD_SIZE   = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input logic               clk_i,
    input logic               rst_i,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t               state_q;
    logic                 we_q;
    logic [2:0]           funct3_q;
    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic                 resp_fault_q;
    logic [WORD_SIZE-1:0] resp_rdata_q;
    logic                 mem_we_q;
    logic [WORD_SIZE-1:0] mem_addr_q;
    logic [WORD_SIZE-1:0] mem_wdata_q;
    logic [1:0]           mem_ctrl_q;
    logic                 legal_d;
    logic                 misaligned_d;
    logic [WORD_SIZE-1:0] rdata_d;

    always_comb begin
        legal_d = bus.req_we ? (bus.req_funct3 inside {3'd0, 3'd1, 3'd2})
                             : (bus.req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        misaligned_d = ALIGN_CHECK &&
                       ((bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
                        (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0));
        // memory already shifts the addressed byte into lane 0; funct3[2] selects zero-extension
        rdata_d = funct3_q[1:0] == 2'd0 ? {{(WORD_SIZE-8){~funct3_q[2] & bus.mem_data[7]}}, bus.mem_data[7:0]} :
                  funct3_q[1:0] == 2'd1 ? {{(WORD_SIZE-16){~funct3_q[2] & bus.mem_data[15]}}, bus.mem_data[15:0]} :
                  bus.mem_data;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_ctrl_q   <= 2'd2;
        end else begin
            case (state_q)
                IDLE: if (bus.req_valid && req_ready_q) begin
                    we_q        <= bus.req_we;
                    funct3_q    <= bus.req_funct3;
                    req_ready_q <= 1'b0;
                    if (legal_d && !misaligned_d) begin
                        state_q     <= ISSUE;
                        mem_we_q    <= bus.req_we;
                        mem_addr_q  <= bus.req_addr;
                        mem_wdata_q <= bus.req_we ? bus.req_wdata : '0;
                        mem_ctrl_q  <= bus.req_funct3[1:0];
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= we_q ? '0 : rdata_d;
                    mem_we_q     <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_wdata_q  <= '0;
                    mem_ctrl_q   <= 2'd2;
                end
                RESP: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // rst gates the write strobe so a reset during ISSUE cannot commit the store
    assign bus.mem_write_en   = mem_we_q & rst_i;
    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.resp_fault     = resp_fault_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.mem_ctrl       = mem_ctrl_q;
endmodule
